// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole player-input path: hole count,
// miss counter width and the round-resolution state encoding.
package wam_pkg;

    localparam int NUM_HOLES = 9;
    localparam int MISS_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        RESOLVED = 2'd2,
        OVER     = 2'd3
    } wam_state_e;

endpackage

// File: rtl/button_debouncer.sv
// One player button: 2-flop synchronizer, stability counter and rising-edge
// detect on the debounced level. press is high for exactly one cycle per
// accepted press; releases produce nothing.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    // Counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta_reg;
    logic             sync_reg;
    logic             deb_reg;
    logic             deb_prev_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
        end else begin
            sync_meta_reg <= btn;
            sync_reg      <= sync_meta_reg;
        end
    end

    // Count consecutive samples that disagree with the debounced level and
    // flip the level once the disagreement has lasted long enough.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
            deb_reg <= 1'b0;
        end else if (sync_reg != deb_reg) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                deb_reg <= ~deb_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end else begin
            cnt_reg <= '0;
        end
    end

    // Remember last debounced level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_prev_reg <= 1'b0;
        end else begin
            deb_prev_reg <= deb_reg;
        end
    end

    assign press = deb_reg & ~deb_prev_reg;

endmodule

// File: rtl/whack_detector.sv
// Player-input side of the whack-a-mole game. Debounces the nine buttons,
// resolves each lit round as a hit or a miss, and keeps score, miss count
// and the sticky game-over flag.
// Optional feature macro: WHACK_PENALTY_EN -- when defined, presses on unlit
// holes (or any press between rounds) cost one point and pulse wrong_pulse.
module whack_detector
    import wam_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCORE_W         = 8,
    parameter int MAX_MISSES      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HOLES-1:0] lights,
    input  logic [NUM_HOLES-1:0] btn,
    output logic [SCORE_W-1:0]   score,
    output logic [MISS_W-1:0]    misses,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 wrong_pulse,
    output logic                 game_over
);

`ifdef WHACK_PENALTY_EN
    localparam bit PENALTY_EN = 1'b1;
`else
    localparam bit PENALTY_EN = 1'b0;
`endif

    localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    logic [NUM_HOLES-1:0] press;

    wam_state_e           state_reg,  state_next;
    logic [NUM_HOLES-1:0] target_reg, target_next;
    logic [SCORE_W-1:0]   score_reg,  score_next;
    logic [MISS_W-1:0]    misses_reg, misses_next;
    logic                 hit_reg,    hit_next;
    logic                 miss_reg,   miss_next;
    logic                 wrong_reg,  wrong_next;
    logic                 wrong_evt;

    // One debouncer per hole.
    generate
        for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk   (clk),
                .reset (reset),
                .btn   (btn[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // Round state, score bookkeeping and registered pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            target_reg <= '0;
            score_reg  <= '0;
            misses_reg <= '0;
            hit_reg    <= 1'b0;
            miss_reg   <= 1'b0;
            wrong_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            score_reg  <= score_next;
            misses_reg <= misses_next;
            hit_reg    <= hit_next;
            miss_reg   <= miss_next;
            wrong_reg  <= wrong_next;
        end
    end

    // Resolve the current round from lights and debounced presses.
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        score_next  = score_reg;
        misses_next = misses_reg;
        hit_next    = 1'b0;
        miss_next   = 1'b0;
        wrong_next  = 1'b0;
        wrong_evt   = 1'b0;

        case (state_reg)
            IDLE: begin
                // Nothing is lit yet, so every press is off-target.
                wrong_evt = |press;
                if (lights != '0) begin
                    target_next = lights;
                    state_next  = ARMED;
                end
            end

            ARMED: begin
                target_next = target_reg | lights;
                if (lights == '0) begin
                    // Light went out first: a simultaneous press is too late.
                    miss_next   = 1'b1;
                    misses_next = misses_reg + MISS_W'(1);
                    state_next  = (misses_next == MISS_LIMIT) ? OVER : IDLE;
                    wrong_evt   = |(press & ~target_reg);
                end else if ((press & target_reg) != '0) begin
                    // Hit beats any off-target press in the same cycle.
                    hit_next   = 1'b1;
                    score_next = (score_reg == SCORE_MAX) ? score_reg
                                                          : score_reg + SCORE_W'(1);
                    state_next = RESOLVED;
                end else begin
                    wrong_evt = |(press & ~target_reg);
                end
            end

            RESOLVED: begin
                if (lights == '0) begin
                    target_next = '0;
                    state_next  = IDLE;
                end
            end

            OVER: begin
                // Frozen until reset.
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (PENALTY_EN && wrong_evt) begin
            wrong_next = 1'b1;
            score_next = (score_reg == '0) ? '0 : score_reg - SCORE_W'(1);
        end
    end

    assign score       = score_reg;
    assign misses      = misses_reg;
    assign hit_pulse   = hit_reg;
    assign miss_pulse  = miss_reg;
    assign wrong_pulse = wrong_reg;
    assign game_over   = (state_reg == OVER);

endmodule

// File: doc/whack_detector.md
Name: whack_detector

Overview:
- Player-input end of the whack-a-mole light interface.
- Watches the 9-bit lights vector driven by the light controller and samples the 9 player buttons.
- Decides hit or miss for each lit round, and keeps the score, miss count and game-over state for the display and top-level game FSM.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a button's debounced state changes (board build overrides to 500000).
- SCORE_W, 8, width of score counter.
- MAX_MISSES, 3, misses that end the game (1..15).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- lights  input  9  one bit per hole from light controller, 1 = lit.
- btn  input  9  raw asynchronous player buttons, active-high, bit i = hole i.
- score  output  SCORE_W  hits minus penalties, saturating.
- misses  output  4  rounds lost.
- hit_pulse  output  1  one-cycle pulse per scored hit.
- miss_pulse  output  1  one-cycle pulse per missed round.
- wrong_pulse  output  1  one-cycle pulse per wrong press (feature only, else 0).
- game_over  output  1  sticky; set when misses reaches MAX_MISSES.

Behaviour:
- Reset (reset=0, async): score=0, misses=0, all pulses=0, game_over=0, state=IDLE, target=0, synchronizers/debounced state/counters=0.

Input path, per button:
- 2-flop synchronizer.
- Debouncer: counter increments while synced value != debounced value, clears when they are equal; debounced value toggles when counter reaches DEBOUNCE_CYCLES-1.
- press[i] = debounced rising edge, one cycle wide.
- Latency: hit_pulse asserts exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples btn[i]=1, provided btn is held stable.

FSM states: IDLE, ARMED, RESOLVED, OVER. target is a 9-bit register.
- IDLE:
  - lights!=0 -> target<=lights, go to ARMED.
  - Presses are ignored.
- ARMED:
  - target<=target|lights every cycle.
  - If lights==0 this cycle -> miss_pulse=1, misses+1, go to IDLE. A press in the same cycle is not a hit: the light already went out.
  - Else if (press & target)!=0 -> hit_pulse=1, score+1 (saturate at 2^SCORE_W-1), go to RESOLVED.
  - Multiple target presses in one cycle count as a single hit.
- RESOLVED:
  - Further presses produce no hit.
  - lights==0 -> go to IDLE, target<=0.
- OVER:
  - Entered on the same edge that misses becomes MAX_MISSES; game_over=1 from that edge onward.
  - No counting or pulses afterwards until reset.
- misses never exceeds MAX_MISSES.
- Pulses are registered and last exactly one cycle.
- Reset mid-round abandons the round with no pulse.

Optional Feature:
- Macro: WHACK_PENALTY_EN.
- Defined:
  - Any press with (press & ~target)!=0 in ARMED, or any press in IDLE, counts as a wrong press.
  - A wrong press gives wrong_pulse=1 and score-1, saturating at 0.
  - If a hit and a wrong press occur in the same cycle, the hit wins: score+1, no wrong_pulse.
  - RESOLVED and OVER: no penalty.
- Undefined: wrong presses are ignored; wrong_pulse tied to 0.

Decomposition:
- Package wam_pkg:
  - NUM_HOLES=9.
  - State enum {IDLE, ARMED, RESOLVED, OVER}.
  - MISS_W=4.
- Sub-module button_debouncer, parameterized by DEBOUNCE_CYCLES: synchronizer + debounce counter + edge detect, producing one press bit.
- Instantiate 9 copies via generate.

Test Plan (DEBOUNCE_CYCLES=4, MAX_MISSES=3):
- Hit: lights=9'h010, btn[4]=1 held -> hit_pulse at edge 7 after btn rise, score=1, state RESOLVED; lights->0 -> IDLE, misses=0.
- Miss: lights=9'h004 for 20 cycles then 0, no btn -> one miss_pulse on the cycle lights=0, misses=1, score=0.
- Glitch rejection: btn[4] high for 3 cycles then low, lights=9'h010 -> no hit_pulse, score=0.
- Game over: 3 consecutive missed rounds -> misses=3, game_over=1; a 4th lit round with a correct press -> score and misses unchanged, no pulses.
- Boundary: press on target debounced in the same cycle lights drops to 0 -> miss_pulse, no hit_pulse; score=255 plus a hit -> score stays 255.
- WHACK_PENALTY_EN: score=2, lights=9'h001, btn[5] press -> wrong_pulse, score=1; btn[0] press -> hit, score=2. At score=0 a wrong press in IDLE -> score stays 0.
